line_burst_adapter: RTL and testbench
=====================================

# line_burst_adapter

Memory-side responder for the cache's 256-bit line port. It accepts one line read or line write from the cache and converts it into a 4-beat, 64-bit burst transaction toward physical memory. It returns a single-cycle response once the burst completes. It sits between the cache's pmem_* port and the burst DRAM model or controller.

## Interface
- Parameters
  - BEATS, default 4: beats per line; must equal 256/64.
- Ports, cache side
  - clk  in  1  clock; everything samples on the rising edge.
  - rst  in  1  synchronous, active-high reset.
  - line_address_i  in  32  line request address from the cache.
  - line_i  in  256  write line from the cache.
  - line_o  out  256  assembled read line.
  - read_i  in  1  line read request.
  - write_i  in  1  line write request.
  - resp_o  out  1  completion pulse.
- Ports, memory side
  - burst_address_o  out  32  line-aligned burst address.
  - burst_i  in  64  read beat data.
  - burst_o  out  64  write beat data.
  - read_o  out  1  burst read request.
  - write_o  out  1  burst write request.
  - resp_i  in  1  beat valid/accepted strobe.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE
  - read_i=1 → latch burst_address_o = {line_address_i[31:5], 5'b0}, clear beat count, go to RD.
  - Else write_i=1 → latch the same aligned address, latch line_i into the write buffer, clear beat count, go to WR.
  - read_i takes priority if both are high.
  - resp_i is ignored.
- RD
  - read_o=1.
  - Each cycle with resp_i=1: line_o[64*cnt +: 64] ← burst_i, then cnt++.
  - On the beat with cnt==BEATS-1: go to DONE; read_o drops that same edge.
  - Cycles with resp_i=0 are gaps: no capture, no count change.
- WR
  - write_o=1; burst_o = wbuf[64*cnt +: 64], registered from cnt.
  - Each cycle with resp_i=1 means the memory took the current beat: cnt++.
  - On the last beat go to DONE; write_o drops.
- DONE
  - resp_o=1 for exactly one cycle, then IDLE.
  - line_o stays stable in DONE and afterwards until the next read's first captured beat.
- Beat order is ascending: beat 0 maps to bits [63:0], beat 3 to bits [255:192].
- cnt is 2 bits, 0..3. Wrap is never taken because the FSM exits on cnt==3.
- read_i/write_i are sampled only in IDLE. Changes mid-transaction are ignored.
- The cache holds its request until resp_o. The adapter returns to IDLE one cycle after resp_o, so a still-high request restarts a new transaction there. The cache must drop its request on the resp_o cycle.
- Reset, including mid-burst: next state IDLE. All of these clear to 0: resp_o, read_o, write_o, burst_address_o, burst_o, line_o, cnt, wbuf. An in-flight burst is abandoned; later resp_i is ignored in IDLE.

## Timing
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Read: request seen at edge E0, so read_o=1 from E0+1.
  - With memory latency L cycles (first resp_i at E0+1+L), beats are captured at E0+1+L .. E0+4+L when back-to-back.
  - resp_o is high in cycle E0+5+L.
  - Minimum request-to-resp_o latency is 5 cycles (L=0).
- Write: same timeline.
  - burst_o holds beat 0 from the first write_o cycle.
  - burst_o changes only on the edge following an accepted beat.
- Gaps in resp_i extend latency one cycle per gap.
- Back-to-back requests: minimum 1 idle cycle between resp_o and the next read_o/write_o.

## Test plan
- Reset then idle: assert rst 2 cycles with read_i=1.
  - Required: all outputs 0.
  - First read_o appears 1 cycle after rst drops.
- Read, no gaps: line_address_i=0x0000_1234, memory returns 0x1111..., 0x2222..., 0x3333..., 0x4444... on 4 consecutive resp_i cycles.
  - Required: burst_address_o=0x0000_1220.
  - Required: line_o = {0x4444...,0x3333...,0x2222...,0x1111...}.
  - Required: single resp_o exactly 1 cycle after the 4th beat.
- Write with gaps: line_i = {64'hD,64'hC,64'hB,64'hA}; resp_i pattern 1,0,1,0,0,1,1.
  - Required: burst_o = A,B,B,C,C,C,D across those cycles.
  - Required: write_o low after the 4th accepted beat; resp_o 1 cycle later.
- Simultaneous read_i and write_i in IDLE.
  - Required: read burst only; write_o never asserts.
- Reset mid-read after 2 beats.
  - Required: read_o=0, line_o=0 next cycle; no resp_o.
  - Required: 2 further resp_i pulses produce no state change.
- Back-to-back reads: request held through resp_o.
  - Required: a second read_o rises 2 cycles after resp_o, with resp_o one-cycle-wide each time.

Source files
------------

// File: rtl/line_burst_adapter.sv
// line_burst_adapter
//   Converts one 256-bit cache line read/write into a BEATS-beat, 64-bit
//   burst toward memory. A one-cycle resp_o follows burst completion.
//   Cache side : line_address_i, line_i, line_o, read_i, write_i, resp_o
//   Memory side: burst_address_o, burst_i, burst_o, read_o, write_o, resp_i
//   Every output is either a register or a decode of the state register,
//   so no input reaches an output combinationally.
module line_burst_adapter #(
  parameter int BEATS = 4
) (
  input  logic         clk,
  input  logic         rst,
  // cache side
  input  logic [31:0]  line_address_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  // memory side
  output logic [31:0]  burst_address_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic [255:0]    wbuf;
  logic            last_beat;

  // Offset bits are dropped by line alignment.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^line_address_i[4:0];

  assign cnt_nxt   = cnt + 1'b1;
  assign last_beat = (cnt == CW'(BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    case (state_q)
      IDLE: begin
        // read wins when both requests are raised together
        if (read_i)       state_d = RD;
        else if (write_i) state_d = WR;
      end
      RD: begin
        read_o = 1'b1;
        if (resp_i && last_beat) state_d = DONE;
      end
      WR: begin
        write_o = 1'b1;
        if (resp_i && last_beat) state_d = DONE;
      end
      DONE: begin
        resp_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt             <= '0;
      wbuf            <= '0;
      line_o          <= '0;
      burst_o         <= '0;
      burst_address_o <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (read_i || write_i) begin
            burst_address_o <= {line_address_i[31:5], 5'b0};
            cnt             <= '0;
          end
          if (!read_i && write_i) begin
            wbuf    <= line_i;
            // beat 0 is presented on the very first write_o cycle
            burst_o <= line_i[63:0];
          end
        end
        RD: begin
          if (resp_i) begin
            line_o[64*cnt +: 64] <= burst_i;
            cnt                  <= cnt_nxt;
          end
        end
        WR: begin
          if (resp_i) begin
            cnt <= cnt_nxt;
            // hold the final beat rather than wrapping back to beat 0
            if (!last_beat) burst_o <= wbuf[64*cnt_nxt +: 64];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_burst_adapter.sv
module tb_line_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  line_address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [31:0]  burst_address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  line_burst_adapter #(.BEATS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .line_address_i  (line_address_i),
    .line_i          (line_i),
    .line_o          (line_o),
    .read_i          (read_i),
    .write_i         (write_i),
    .resp_o          (resp_o),
    .burst_address_o (burst_address_o),
    .burst_i         (burst_i),
    .burst_o         (burst_o),
    .read_o          (read_o),
    .write_o         (write_o),
    .resp_i          (resp_i)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] B1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] B2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] B3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] B4 = 64'h4444_4444_4444_4444;

  logic [63:0] wexp [7];
  logic        wpat [7];
  logic [63:0] rbeats [4];

  initial begin
    rst = 1'b1; read_i = 1'b1; write_i = 1'b0; resp_i = 1'b0;
    line_address_i = 32'h0; line_i = '0; burst_i = '0;

    // reset with a read pending
    #1;
    step(); step();
    check("rst_read_o",  read_o,  0);
    check("rst_write_o", write_o, 0);
    check("rst_resp_o",  resp_o,  0);
    check("rst_line_o",  line_o,  0);
    check("rst_burst_o", burst_o, 0);
    check("rst_addr",    burst_address_o, 0);
    rst = 1'b0;
    step();
    check("first_read_o", read_o, 1);
    rst = 1'b1; read_i = 1'b0;
    step();
    rst = 1'b0;
    check("rst2_read_o", read_o, 0);

    // read, no gaps
    line_address_i = 32'h0000_1234; read_i = 1'b1;
    step();
    check("rd_read_o", read_o, 1);
    check("rd_addr", burst_address_o, 32'h0000_1220);
    rbeats = '{B1, B2, B3, B4};
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("rd_resp_low", resp_o, 0);
      burst_i = rbeats[i];
      step();
    end
    check("rd_resp_o", resp_o, 1);
    check("rd_read_o_drop", read_o, 0);
    check("rd_line_o", line_o, {B4, B3, B2, B1});
    read_i = 1'b0; resp_i = 1'b0;
    step();
    check("rd_resp_pulse", resp_o, 0);
    check("rd_line_hold", line_o, {B4, B3, B2, B1});

    // write with gaps
    line_i = {64'hD, 64'hC, 64'hB, 64'hA}; write_i = 1'b1; line_address_i = 32'h0000_0FFF;
    step();
    check("wr_write_o", write_o, 1);
    check("wr_addr", burst_address_o, 32'h0000_0FE0);
    wpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    wexp = '{64'hA, 64'hB, 64'hB, 64'hC, 64'hC, 64'hC, 64'hD};
    for (int i = 0; i < 7; i++) begin
      check($sformatf("wr_burst_o[%0d]", i), burst_o, wexp[i]);
      check($sformatf("wr_write_o[%0d]", i), write_o, 1);
      check($sformatf("wr_resp_low[%0d]", i), resp_o, 0);
      resp_i = wpat[i];
      step();
    end
    check("wr_write_drop", write_o, 0);
    check("wr_resp_o", resp_o, 1);
    write_i = 1'b0; resp_i = 1'b0;
    step();
    check("wr_resp_pulse", resp_o, 0);

    // simultaneous read and write: read wins
    read_i = 1'b1; write_i = 1'b1; line_address_i = 32'h0000_0040;
    step();
    check("both_read_o", read_o, 1);
    check("both_write_o", write_o, 0);
    rbeats = '{64'h5, 64'h6, 64'h7, 64'h8};
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      burst_i = rbeats[i];
      step();
      check($sformatf("both_no_write[%0d]", i), write_o, 0);
    end
    check("both_resp_o", resp_o, 1);
    check("both_line_o", line_o, {64'h8, 64'h7, 64'h6, 64'h5});
    read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    step();
    step();
    check("both_idle_write_o", write_o, 0);

    // reset in the middle of a read, after two beats
    read_i = 1'b1; line_address_i = 32'h0000_2000;
    step();
    resp_i = 1'b1;
    burst_i = 64'hAA; step();
    burst_i = 64'hBB; step();
    check("mid_partial_line", line_o[127:0], {64'hBB, 64'hAA});
    resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
    step();
    rst = 1'b0;
    check("mid_read_o", read_o, 0);
    check("mid_line_o", line_o, 0);
    check("mid_resp_o", resp_o, 0);
    resp_i = 1'b1; burst_i = 64'hCC;
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("mid_stray_read_o[%0d]", i), read_o, 0);
      check($sformatf("mid_stray_resp_o[%0d]", i), resp_o, 0);
      check($sformatf("mid_stray_line_o[%0d]", i), line_o, 0);
    end
    resp_i = 1'b0;

    // back-to-back reads with the request held through resp_o
    read_i = 1'b1; line_address_i = 32'h0000_3000;
    step();
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin burst_i = 64'(i + 1); step(); end
    check("b2b_resp1", resp_o, 1);
    resp_i = 1'b0;
    step();
    check("b2b_resp1_pulse", resp_o, 0);
    check("b2b_gap_read_o", read_o, 0);
    step();
    check("b2b_read_o2", read_o, 1);
    check("b2b_resp_low", resp_o, 0);
    resp_i = 1'b1;
    for (int i = 0; i < 4; i++) begin burst_i = 64'(i + 9); step(); end
    check("b2b_resp2", resp_o, 1);
    check("b2b_line2", line_o, {64'hC, 64'hB, 64'hA, 64'h9});
    read_i = 1'b0; resp_i = 1'b0;
    step();
    check("b2b_resp2_pulse", resp_o, 0);
    check("b2b_final_read_o", read_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
